dcache_line_ctrl: RTL and testbench

Memory-side controller for data-cache block transfers, serving the block-refill and dirty-writeback interface of the memory stage. On a data-cache miss it writes back the victim block when dirty, then fetches the missing block. Both transfers use a beat-serialized valid/ready memory bus. It returns the assembled block to the cache with a one-cycle block write enable and holds the pipeline busy while a transfer is in flight.

---
 rtl/dcache_line_ctrl.sv | 126 ++++++++++++
 tb/tb_dcache_line_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_line_ctrl.sv
// Data-cache block transfer engine: optional dirty-victim writeback, then an 8-beat refill, then a one-cycle block write strobe.
// Latency: 10 cycles from miss to strobe for a clean miss, 20 for a dirty miss, on a zero-wait bus; every memory stall adds one cycle.
module dcache_line_ctrl #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_miss,
  input  logic                   i_dirty,
  input  logic [ADDR_WIDTH-1:0]  i_miss_addr,
  input  logic [ADDR_WIDTH-1:0]  i_wb_addr,
  input  logic [BLOCK_WIDTH-1:0] i_wb_block,
  output logic                   o_block_we,
  output logic [BLOCK_WIDTH-1:0] o_data_block,
  output logic                   o_busy,
  output logic                   o_req_valid,
  input  logic                   i_req_ready,
  output logic [ADDR_WIDTH-1:0]  o_req_addr,
  output logic                   o_req_write,
  output logic                   o_wvalid,
  input  logic                   i_wready,
  output logic [DATA_WIDTH-1:0]  o_wdata,
  output logic                   o_wlast,
  input  logic                   i_bvalid,
  output logic                   o_bready,
  input  logic                   i_rvalid,
  output logic                   o_rready,
  input  logic [DATA_WIDTH-1:0]  i_rdata
);

  localparam int BEATS = BLOCK_WIDTH / DATA_WIDTH;
  localparam int OFS   = $clog2(BLOCK_WIDTH / 8);
  localparam int CW    = $clog2(BEATS);
  localparam int DSH   = $clog2(DATA_WIDTH);
  localparam int BSH   = $clog2(BLOCK_WIDTH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE, WB_ADDR, WB_DATA, WB_RESP, RD_ADDR, RD_DATA, FILL
  } state_t;

  state_t                       state, state_nxt;
  logic [CW-1:0]                beat;
  logic [BSH-1:0]               beat_ofs;
  logic [BLOCK_WIDTH-1:0]       wb_buf;
  logic [BLOCK_WIDTH-1:0]       fill_buf;
  logic [ADDR_WIDTH-OFS-1:0]    wb_blk_addr;
  logic [ADDR_WIDTH-OFS-1:0]    miss_blk_addr;
  logic                         w_fire;
  logic                         r_fire;
  logic                         unused_addr_bits;

  // Byte offset inside the block is irrelevant: only block-aligned addresses go out.
  assign unused_addr_bits = ^{i_miss_addr[OFS-1:0], i_wb_addr[OFS-1:0]};

  assign beat_ofs = {beat, {DSH{1'b0}}};
  assign w_fire   = (state == WB_DATA) && i_wready;
  assign r_fire   = (state == RD_DATA) && i_rvalid;

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_miss) state_nxt = i_dirty ? WB_ADDR : RD_ADDR;
      WB_ADDR: if (i_req_ready) state_nxt = WB_DATA;
      WB_DATA: if (i_wready && (beat == LAST_BEAT)) state_nxt = WB_RESP;
      WB_RESP: if (i_bvalid) state_nxt = RD_ADDR;
      RD_ADDR: if (i_req_ready) state_nxt = RD_DATA;
      RD_DATA: if (i_rvalid && (beat == LAST_BEAT)) state_nxt = FILL;
      FILL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture happens only on the IDLE->transfer edge, so later input changes are ignored.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      beat          <= '0;
      wb_buf        <= '0;
      fill_buf      <= '0;
      wb_blk_addr   <= '0;
      miss_blk_addr <= '0;
    end else begin
      if ((state == IDLE) && i_miss) begin
        miss_blk_addr <= i_miss_addr[ADDR_WIDTH-1:OFS];
        if (i_dirty) begin
          wb_blk_addr <= i_wb_addr[ADDR_WIDTH-1:OFS];
          wb_buf      <= i_wb_block;
        end
      end
      if (r_fire) begin
        fill_buf[beat_ofs +: DATA_WIDTH] <= i_rdata;
      end
      // Counter width equals log2(BEATS), so the last beat wraps it back to zero.
      if (w_fire || r_fire) begin
        beat <= beat + 1'b1;
      end
    end
  end

  always_comb begin
    o_busy       = (state != IDLE);
    o_req_valid  = (state == WB_ADDR) || (state == RD_ADDR);
    o_req_write  = (state == WB_ADDR);
    o_req_addr   = '0;
    if (state == WB_ADDR) o_req_addr = {wb_blk_addr, {OFS{1'b0}}};
    if (state == RD_ADDR) o_req_addr = {miss_blk_addr, {OFS{1'b0}}};
    o_wvalid     = (state == WB_DATA);
    o_wdata      = (state == WB_DATA) ? wb_buf[beat_ofs +: DATA_WIDTH] : '0;
    o_wlast      = (state == WB_DATA) && (beat == LAST_BEAT);
    o_bready     = (state == WB_RESP);
    o_rready     = (state == RD_DATA);
    o_block_we   = (state == FILL);
    o_data_block = (state == FILL) ? fill_buf : '0;
  end

endmodule

// File: tb/tb_dcache_line_ctrl.sv
// Bench for dcache_line_ctrl: a memory responder with configurable stalls, a scoreboard of expected
// requests, write beats and refilled blocks, and a monitor that checks every DUT handshake against it.
module tb_dcache_line_ctrl;

  logic         clk;
  logic         i_arst;
  logic         i_miss;
  logic         i_dirty;
  logic [63:0]  i_miss_addr;
  logic [63:0]  i_wb_addr;
  logic [511:0] i_wb_block;
  logic         o_block_we;
  logic [511:0] o_data_block;
  logic         o_busy;
  logic         o_req_valid;
  logic         i_req_ready;
  logic [63:0]  o_req_addr;
  logic         o_req_write;
  logic         o_wvalid;
  logic         i_wready;
  logic [63:0]  o_wdata;
  logic         o_wlast;
  logic         i_bvalid;
  logic         o_bready;
  logic         i_rvalid;
  logic         o_rready;
  logic [63:0]  i_rdata;

  dcache_line_ctrl #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .BLOCK_WIDTH(512)) dut (
    .i_clk(clk), .i_arst(i_arst), .i_miss(i_miss), .i_dirty(i_dirty),
    .i_miss_addr(i_miss_addr), .i_wb_addr(i_wb_addr), .i_wb_block(i_wb_block),
    .o_block_we(o_block_we), .o_data_block(o_data_block), .o_busy(o_busy),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_addr(o_req_addr),
    .o_req_write(o_req_write), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .o_wdata(o_wdata), .o_wlast(o_wlast), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata)
  );

  typedef struct packed { logic wr; logic [63:0] addr; } req_t;
  typedef struct packed { logic last; logic [63:0] data; } wbeat_t;

  req_t         exp_req[$];
  wbeat_t       exp_w[$];
  logic [511:0] exp_blk[$];
  int           exp_fcyc[$];

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           t0 = 0;
  int           fills = 0;
  int           rd_k = 0;
  bit           w_toggle = 0;
  int           rgap = 0;
  int           bdelay = 0;
  logic [63:0]  rd_off = '0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [511:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  // Memory responder: drives handshakes at negedge, records read fires just before the next posedge.
  initial begin
    int gap;
    int bcnt;
    bit rf;
    gap = 0; bcnt = 0; rf = 0;
    i_req_ready = 0; i_wready = 0; i_bvalid = 0; i_rvalid = 0; i_rdata = '0;
    forever begin
      @(negedge clk);
      if (rf) begin
        rd_k++;
        gap = rgap;
      end else if (!o_rready) begin
        rd_k = 0;
        gap = 0;
      end
      i_req_ready = w_toggle ? ~i_req_ready : 1'b1;
      i_wready    = w_toggle ? ~i_wready : 1'b1;
      if (o_bready) bcnt++; else bcnt = 0;
      i_bvalid = o_bready && (bcnt > bdelay);
      if (gap > 0) begin
        i_rvalid = 0;
        gap--;
      end else begin
        i_rvalid = 1;
      end
      i_rdata = 64'h11 * 64'(rd_k) + rd_off;
      #4 rf = i_rvalid && o_rready && i_arst;
    end
  end

  // Monitor: compares every handshake and strobe with the scoreboard, and checks held data under stall.
  initial begin
    bit          pw_stall, pr_stall;
    logic [63:0] pw_dat, pr_addr;
    logic        pw_last, pr_wr;
    pw_stall = 0; pr_stall = 0; pw_dat = '0; pr_addr = '0; pw_last = 0; pr_wr = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!i_arst) begin
        pw_stall = 0;
        pr_stall = 0;
        continue;
      end
      if (pw_stall) begin
        chk("w_hold_valid", o_wvalid, 1'b1);
        chk("w_hold_data", o_wdata, pw_dat);
        chk("w_hold_last", o_wlast, pw_last);
      end
      if (pr_stall) begin
        chk("req_hold_valid", o_req_valid, 1'b1);
        chk("req_hold_addr", o_req_addr, pr_addr);
        chk("req_hold_write", o_req_write, pr_wr);
      end
      if (o_req_valid && i_req_ready) begin
        if (exp_req.size() == 0) fail_now("req_extra", o_req_addr);
        else begin
          req_t e;
          e = exp_req.pop_front();
          chk("req_addr", o_req_addr, e.addr);
          chk("req_write", o_req_write, e.wr);
        end
      end
      if (o_wvalid && i_wready) begin
        if (exp_w.size() == 0) fail_now("wbeat_extra", o_wdata);
        else begin
          wbeat_t e;
          e = exp_w.pop_front();
          chk("wbeat_data", o_wdata, e.data);
          chk("wbeat_last", o_wlast, e.last);
        end
      end
      if (o_block_we) begin
        if (exp_blk.size() == 0) fail_now("fill_extra", o_data_block);
        else begin
          int c;
          chk("fill_block", o_data_block, exp_blk.pop_front());
          c = exp_fcyc.pop_front();
          if (c >= 0) chk("fill_cycle", 512'(cyc - t0), 512'(c));
        end
        fills++;
      end
      pw_stall = o_wvalid && !i_wready;
      pw_dat   = o_wdata;
      pw_last  = o_wlast;
      pr_stall = o_req_valid && !i_req_ready;
      pr_addr  = o_req_addr;
      pr_wr    = o_req_write;
    end
  end

  task automatic push_read(input logic [63:0] maddr, input logic [63:0] off, input int fcyc);
    logic [511:0] b;
    exp_req.push_back('{wr: 1'b0, addr: {maddr[63:6], 6'b0}});
    for (int k = 0; k < 8; k++) b[k*64 +: 64] = 64'h11 * 64'(k) + off;
    exp_blk.push_back(b);
    exp_fcyc.push_back(fcyc);
  endtask

  task automatic push_wb(input logic [63:0] waddr, input logic [511:0] wblk);
    exp_req.push_back('{wr: 1'b1, addr: {waddr[63:6], 6'b0}});
    for (int k = 0; k < 8; k++) exp_w.push_back('{last: (k == 7), data: wblk[k*64 +: 64]});
  endtask

  task automatic start_miss(input logic dirty, input logic [63:0] maddr,
                            input logic [63:0] waddr, input logic [511:0] wblk);
    @(negedge clk);
    i_miss = 1; i_dirty = dirty; i_miss_addr = maddr; i_wb_addr = waddr; i_wb_block = wblk;
    t0 = cyc;
    @(negedge clk);
    i_miss = 0; i_dirty = 0;
  endtask

  task automatic wait_fill(input string name);
    int n0;
    n0 = fills;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #3;
      if (fills != n0) break;
    end
    chk({name, "_fill_count"}, 512'(fills - n0), 512'd1);
    chk({name, "_req_q"}, 512'(exp_req.size()), 512'd0);
    chk({name, "_w_q"}, 512'(exp_w.size()), 512'd0);
    chk({name, "_blk_q"}, 512'(exp_blk.size()), 512'd0);
  endtask

  initial begin
    logic [511:0] wblk;
    i_arst = 0; i_miss = 0; i_dirty = 0; i_miss_addr = '0; i_wb_addr = '0; i_wb_block = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_req_valid", o_req_valid, 1'b0);
    chk("rst_block_we", o_block_we, 1'b0);
    chk("rst_data_block", o_data_block, '0);
    chk("rst_handshakes", {o_wvalid, o_wlast, o_bready, o_rready, o_req_write}, '0);
    @(negedge clk);
    i_arst = 1;
    repeat (2) @(negedge clk);

    // Clean miss, zero-wait memory
    rd_off = 64'h0;
    push_read(64'h1000_0048, 64'h0, 10);
    start_miss(1'b0, 64'h1000_0048, 64'h0, '0);
    #2;
    chk("clean_busy", o_busy, 1'b1);
    wait_fill("clean");
    @(negedge clk);
    #2;
    chk("clean_idle_busy", o_busy, 1'b0);
    chk("clean_we_single", o_block_we, 1'b0);

    // Dirty miss, zero-wait memory
    for (int k = 0; k < 8; k++) wblk[k*64 +: 64] = 64'(k + 1);
    rd_off = 64'h100;
    push_wb(64'h2000_0000, wblk);
    push_read(64'h4000_1234, 64'h100, 20);
    start_miss(1'b1, 64'h4000_1234, 64'h2000_0000, wblk);
    wait_fill("dirty");

    // Backpressure on every channel
    for (int k = 0; k < 8; k++) wblk[k*64 +: 64] = 64'hA5A5_0000_0000_0000 + 64'(k * 3 + 1);
    w_toggle = 1; rgap = 3; rd_off = 64'h200;
    push_wb(64'h5000_0080, wblk);
    push_read(64'h6000_007F, 64'h200, -1);
    start_miss(1'b1, 64'h6000_007F, 64'h5000_0080, wblk);
    wait_fill("bp");
    w_toggle = 0; rgap = 0;
    repeat (2) @(negedge clk);

    // Late write response, with inputs scrambled right after capture
    for (int k = 0; k < 8; k++) wblk[k*64 +: 64] = 64'(8'hF0 + k);
    bdelay = 5; rd_off = 64'h300;
    push_wb(64'h7000_01C8, wblk);
    push_read(64'h7100_0010, 64'h300, 25);
    start_miss(1'b1, 64'h7100_0010, 64'h7000_01C8, wblk);
    i_wb_block = '1; i_wb_addr = 64'hDEAD_BEEF_0000_0000; i_miss_addr = 64'hCAFE_0000_0000_0000;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (o_bready) break;
    end
    chk("late_bready_seen", o_bready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #2;
      end
      chk("late_bready_held", o_bready, 1'b1);
      chk("late_no_read_req", o_req_valid, 1'b0);
    end
    wait_fill("late");
    bdelay = 0;
    i_wb_block = '0; i_wb_addr = '0; i_miss_addr = '0;

    // Reset in the middle of the refill, then a fresh refill
    rd_off = 64'h500;
    exp_req.push_back('{wr: 1'b0, addr: 64'h8000_0000});
    start_miss(1'b0, 64'h8000_0008, 64'h0, '0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (rd_k >= 4) break;
    end
    chk("abort_beats_done", 512'(rd_k), 512'd4);
    #2;
    i_arst = 0;
    #1;
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_rready", o_rready, 1'b0);
    chk("abort_block_we", o_block_we, 1'b0);
    chk("abort_data_block", o_data_block, '0);
    repeat (2) @(negedge clk);
    i_arst = 1;
    #1;
    chk("abort_release_busy", o_busy, 1'b0);
    chk("abort_req_q", 512'(exp_req.size()), 512'd0);
    rd_off = 64'h400;
    push_read(64'h9000_0100, 64'h400, 10);
    start_miss(1'b0, 64'h9000_0100, 64'h0, '0);
    wait_fill("after_rst");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
